tlb_search_arbiter: RTL and testbench

//   Shares the single TLB search port between three requesters: instruction fetch (IF),

---
 rtl/tlb_search_arbiter.sv | 162 ++++++++++++++++
 tb/tb_tlb_search_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_search_arbiter.sv
// Purpose: shares one TLB search port between IF, MEM and CSR requesters (CSR > MEM > IF, IF anti-starvation).
// Latency: accept at T, search port driven at T+1, registered result valid at T+2; 3-cycle minimum pitch.
// Backpressure: response held stable until the owner's rsp_ready; no new grant until the handshake (or a flush).
module tlb_search_arbiter #(
   parameter int TLBNUM       = 16,
   parameter int IDX_W        = $clog2(TLBNUM),
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic [9:0]       asid,
   input  logic [2:0]       req_valid,
   output logic [2:0]       req_ready,
   input  logic [31:0]      req_vaddr_if,
   input  logic [31:0]      req_vaddr_mem,
   input  logic [31:0]      req_vaddr_csr,
   output logic [18:0]      s_vppn,
   output logic             s_va_bit12,
   output logic [9:0]       s_asid,
   input  logic             s_found,
   input  logic [IDX_W-1:0] s_index,
   input  logic [19:0]      s_ppn,
   input  logic [5:0]       s_ps,
   input  logic [1:0]       s_plv,
   input  logic [1:0]       s_mat,
   input  logic             s_d,
   input  logic             s_v,
   output logic [2:0]       rsp_valid,
   input  logic [2:0]       rsp_ready,
   output logic             rsp_found,
   output logic [IDX_W-1:0] rsp_index,
   output logic [19:0]      rsp_ppn,
   output logic [5:0]       rsp_ps,
   output logic [1:0]       rsp_plv,
   output logic [1:0]       rsp_mat,
   output logic             rsp_d,
   output logic             rsp_v,
   output logic [31:0]      rsp_vaddr
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOOK = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] index;
      logic [19:0]      ppn;
      logic [5:0]       ps;
      logic [1:0]       plv;
      logic [1:0]       mat;
      logic             d;
      logic             v;
   } tlb_res_t;

   state_t           state, state_nxt;
   logic [2:0]       owner_q;
   logic [31:0]      vaddr_q;
   logic [9:0]       asid_q;
   logic [CNT_W-1:0] starve_cnt;
   tlb_res_t         res_q;
   tlb_res_t         res_in;
   logic [2:0]       grant;
   logic [31:0]      grant_vaddr;
   logic             owner_hs;

   assign res_in = '{found: s_found, index: s_index, ppn: s_ppn, ps: s_ps,
                     plv: s_plv, mat: s_mat, d: s_d, v: s_v};

   // Grant selection: IF forced first once starved, otherwise CSR > MEM > IF; only in IDLE without flush.
   always_comb begin
      grant       = 3'b000;
      grant_vaddr = 32'h0;
      if (state == IDLE && !flush) begin
         if (starve_cnt == CNT_W'(STARVE_LIMIT) && req_valid[0]) begin
            grant = 3'b001;
         end else if (req_valid[2]) begin
            grant = 3'b100;
         end else if (req_valid[1]) begin
            grant = 3'b010;
         end else if (req_valid[0]) begin
            grant = 3'b001;
         end
      end
      unique case (grant)
         3'b100:  grant_vaddr = req_vaddr_csr;
         3'b010:  grant_vaddr = req_vaddr_mem;
         3'b001:  grant_vaddr = req_vaddr_if;
         default: grant_vaddr = 32'h0;
      endcase
   end

   assign owner_hs = |(rsp_ready & owner_q);

   // Next-state: a flush in LOOK/RESP abandons the lookup; an owner handshake in RESP ends it normally.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (grant != 3'b000) state_nxt = LOOK;
         LOOK:    state_nxt = flush ? IDLE : RESP;
         RESP:    if (flush || owner_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Request latches: owner, vaddr and ASID are frozen at accept so later input changes cannot leak in.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         owner_q <= 3'b000;
         vaddr_q <= 32'h0;
         asid_q  <= 10'h0;
      end else if (grant != 3'b000) begin
         owner_q <= grant;
         vaddr_q <= grant_vaddr;
         asid_q  <= asid;
      end
   end

   // Starvation counter: counts MEM/CSR wins that IF sat through, saturating; any IF win clears it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt <= '0;
      end else if (grant == 3'b001) begin
         starve_cnt <= '0;
      end else if (grant != 3'b000 && req_valid[0] && starve_cnt != CNT_W'(STARVE_LIMIT)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Result register: the combinational TLB answer is captured at the end of LOOK and held through RESP.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) res_q <= '0;
      else if (state == LOOK && !flush) res_q <= res_in;
   end

   assign req_ready  = grant;
   assign rsp_valid  = (state == RESP) ? owner_q : 3'b000;
   assign s_vppn     = vaddr_q[31:13];
   assign s_va_bit12 = vaddr_q[12];
   assign s_asid     = asid_q;
   assign rsp_found  = res_q.found;
   assign rsp_index  = res_q.index;
   assign rsp_ppn    = res_q.ppn;
   assign rsp_ps     = res_q.ps;
   assign rsp_plv    = res_q.plv;
   assign rsp_mat    = res_q.mat;
   assign rsp_d      = res_q.d;
   assign rsp_v      = res_q.v;
   assign rsp_vaddr  = vaddr_q;

endmodule

// File: tb/tb_tlb_search_arbiter.sv
// Purpose: directed checks of grant priority, anti-starvation, latency, backpressure, flush and async reset.
// Latency: inputs driven 1ns after posedge, outputs checked 2ns after posedge.
// Backpressure: exercised by holding rsp_ready low while the response is pending.
module tb_tlb_search_arbiter;

   logic        clk;
   logic        resetn;
   logic        flush;
   logic [9:0]  asid;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [31:0] req_vaddr_if, req_vaddr_mem, req_vaddr_csr;
   logic [18:0] s_vppn;
   logic        s_va_bit12;
   logic [9:0]  s_asid;
   logic        s_found;
   logic [3:0]  s_index;
   logic [19:0] s_ppn;
   logic [5:0]  s_ps;
   logic [1:0]  s_plv, s_mat;
   logic        s_d, s_v;
   logic [2:0]  rsp_valid;
   logic [2:0]  rsp_ready;
   logic        rsp_found;
   logic [3:0]  rsp_index;
   logic [19:0] rsp_ppn;
   logic [5:0]  rsp_ps;
   logic [1:0]  rsp_plv, rsp_mat;
   logic        rsp_d, rsp_v;
   logic [31:0] rsp_vaddr;

   int errors = 0;
   int checks = 0;

   tlb_search_arbiter #(.TLBNUM(16), .IDX_W(4), .STARVE_LIMIT(4)) dut (
      .clk(clk), .resetn(resetn), .flush(flush), .asid(asid),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_vaddr_if(req_vaddr_if), .req_vaddr_mem(req_vaddr_mem), .req_vaddr_csr(req_vaddr_csr),
      .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
      .s_found(s_found), .s_index(s_index), .s_ppn(s_ppn), .s_ps(s_ps),
      .s_plv(s_plv), .s_mat(s_mat), .s_d(s_d), .s_v(s_v),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_found(rsp_found), .rsp_index(rsp_index), .rsp_ppn(rsp_ppn), .rsp_ps(rsp_ps),
      .rsp_plv(rsp_plv), .rsp_mat(rsp_mat), .rsp_d(rsp_d), .rsp_v(rsp_v),
      .rsp_vaddr(rsp_vaddr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   initial begin
      logic [2:0] exp_own;
      resetn = 1'b0; flush = 1'b0; asid = 10'h0; req_valid = 3'b000; rsp_ready = 3'b000;
      req_vaddr_if = 32'h0; req_vaddr_mem = 32'h0; req_vaddr_csr = 32'h0;
      s_found = 1'b0; s_index = 4'h0; s_ppn = 20'h0; s_ps = 6'h0;
      s_plv = 2'b00; s_mat = 2'b00; s_d = 1'b0; s_v = 1'b0;

      // Reset state
      #2;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_s_vppn",    32'(s_vppn),    32'h0);
      chk("rst_s_asid",    32'(s_asid),    32'h0);
      chk("rst_rsp_ppn",   32'(rsp_ppn),   32'h0);
      chk("rst_rsp_vaddr", rsp_vaddr,      32'h0);
      @(negedge clk); resetn = 1'b1;
      tick;

      // 1. Single IF hit
      asid = 10'h001; req_valid = 3'b001; req_vaddr_if = 32'h1C00_2000;
      settle;
      chk("t1_grant", 32'(req_ready), 32'h1);
      tick;
      req_valid = 3'b000;
      s_found = 1'b1; s_index = 4'h5; s_ppn = 20'h00123; s_ps = 6'd12;
      s_plv = 2'b11; s_mat = 2'b01; s_d = 1'b1; s_v = 1'b1;
      settle;
      chk("t1_s_vppn",  32'(s_vppn),     32'h0E001);
      chk("t1_s_bit12", 32'(s_va_bit12), 32'h0);
      chk("t1_s_asid",  32'(s_asid),     32'h001);
      chk("t1_no_grant_look", 32'(req_ready), 32'h0);
      tick;
      settle;
      chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t1_rsp_ppn",   32'(rsp_ppn),   32'h00123);
      chk("t1_rsp_found", 32'(rsp_found), 32'h1);
      chk("t1_rsp_ps",    32'(rsp_ps),    32'd12);
      chk("t1_rsp_index", 32'(rsp_index), 32'h5);
      chk("t1_rsp_vaddr", rsp_vaddr,      32'h1C00_2000);
      rsp_ready = 3'b001;
      tick;
      rsp_ready = 3'b000;
      settle;
      chk("t1_idle_rsp_valid", 32'(rsp_valid), 32'h0);

      // 3. Backpressure on a MEM lookup (vaddr bit 12 set)
      req_valid = 3'b010; req_vaddr_mem = 32'h0000_3000;
      settle;
      chk("t3_grant", 32'(req_ready), 32'h2);
      tick;
      req_valid = 3'b000; s_found = 1'b1; s_ppn = 20'hABCDE;
      settle;
      chk("t3_s_bit12", 32'(s_va_bit12), 32'h1);
      tick;
      s_ppn = 20'h11111; req_valid = 3'b111; rsp_ready = 3'b101;
      for (int i = 0; i < 5; i++) begin
         settle;
         chk("t3_hold_valid", 32'(rsp_valid), 32'h2);
         chk("t3_hold_ppn",   32'(rsp_ppn),   32'hABCDE);
         chk("t3_hold_ready", 32'(req_ready), 32'h0);
         tick;
      end
      req_valid = 3'b000; rsp_ready = 3'b010;
      tick;
      rsp_ready = 3'b000;
      settle;
      chk("t3_released", 32'(rsp_valid), 32'h0);

      // 2. Priority with all three requesting: four CSR grants, then IF on the fifth
      req_valid = 3'b111; rsp_ready = 3'b111;
      for (int g = 0; g < 5; g++) begin
         exp_own = (g < 4) ? 3'b100 : 3'b001;
         settle;
         chk("t2_all_grant", 32'(req_ready), 32'(exp_own));
         tick;
         tick;
         settle;
         chk("t2_all_owner", 32'(rsp_valid), 32'(exp_own));
         tick;
      end
      // MEM+IF held: four MEM grants, then IF
      req_valid = 3'b011;
      for (int g = 0; g < 5; g++) begin
         exp_own = (g < 4) ? 3'b010 : 3'b001;
         settle;
         chk("t2_memif_grant", 32'(req_ready), 32'(exp_own));
         tick;
         tick;
         tick;
      end
      req_valid = 3'b000; rsp_ready = 3'b000;
      tick;

      // 4. Flush in LOOK
      req_valid = 3'b001; req_vaddr_if = 32'h0000_4000;
      settle;
      chk("t4_grant", 32'(req_ready), 32'h1);
      tick;
      flush = 1'b1;
      settle;
      chk("t4_look_ready", 32'(req_ready), 32'h0);
      tick;
      settle;
      chk("t4_no_rsp",       32'(rsp_valid), 32'h0);
      chk("t4_flush_blocks", 32'(req_ready), 32'h0);
      tick;
      flush = 1'b0;
      settle;
      chk("t4_no_rsp2",     32'(rsp_valid), 32'h0);
      chk("t4_regrant",     32'(req_ready), 32'h1);
      tick;
      req_valid = 3'b000; rsp_ready = 3'b001;
      tick;
      tick;
      rsp_ready = 3'b000;
      tick;

      // 5. Miss with ASID and vaddr changing after accept
      asid = 10'h001; req_valid = 3'b100; req_vaddr_csr = 32'h8000_0000;
      settle;
      chk("t5_grant", 32'(req_ready), 32'h4);
      tick;
      req_valid = 3'b000; asid = 10'h002; req_vaddr_csr = 32'h1234_5678;
      s_found = 1'b0; s_ppn = 20'h0F0F0;
      settle;
      chk("t5_s_asid", 32'(s_asid), 32'h001);
      chk("t5_s_vppn", 32'(s_vppn), 32'h40000);
      tick;
      settle;
      chk("t5_rsp_valid", 32'(rsp_valid), 32'h4);
      chk("t5_rsp_found", 32'(rsp_found), 32'h0);
      chk("t5_rsp_ppn",   32'(rsp_ppn),   32'h0F0F0);

      // 6. Async reset while the response is pending
      #2;
      resetn = 1'b0;
      #1;
      chk("t6_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("t6_rsp_ppn",   32'(rsp_ppn),   32'h0);
      chk("t6_s_vppn",    32'(s_vppn),    32'h0);
      chk("t6_s_asid",    32'(s_asid),    32'h0);
      chk("t6_rsp_vaddr", rsp_vaddr,      32'h0);
      chk("t6_req_ready", 32'(req_ready), 32'h0);
      @(negedge clk); resetn = 1'b1;
      tick;
      req_valid = 3'b001;
      settle;
      chk("t6_idle_grant", 32'(req_ready), 32'h1);
      chk("t6_idle_rsp",   32'(rsp_valid), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
